alu_arbiter: RTL
================

# alu_arbiter

Sequencer and arbiter that shares one combinational `alu` (32-bit; ALUControl 000 ADD, 001 SUB, 010 AND, 011 OR, 100 DIV, 101 UMUL, 110 SMUL, 111 MUL) between two requesters. A requester is, for example, the multi-cycle controller and a long-multiply/divide helper. The block grants requests round-robin and latches operands. It holds the ALU inputs stable for a per-operation latency so that the DIV and multiply paths can be timed as multi-cycle paths. It then returns Result, ResultHi and ALUFlags tagged with the requester ID.

## Interface
Parameters:
- `LAT_MUL`, default 2: EXEC cycles for 101/110/111. Legal values are 1 to 15.
- `LAT_DIV`, default 4: EXEC cycles for 100. Legal values are 1 to 15.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-low. 0 = reset.
- `req_valid` in 2: request valid, one bit per requester.
- `req_ready` out 2: request accepted this cycle. One-hot or zero.
- `req0_a`, `req0_b` in 32 each: requester 0 operands.
- `req0_ctrl` in 3: requester 0 ALUControl code.
- `req1_a`, `req1_b` in 32 each: requester 1 operands.
- `req1_ctrl` in 3: requester 1 ALUControl code.
- `alu_a`, `alu_b` out 32 each: to the ALU `a` and `b` inputs.
- `alu_ctrl` out 3: to the ALU `ALUControl` input.
- `alu_result`, `alu_resulthi` in 32 each: from the ALU.
- `alu_flags` in 4: from the ALU, ordered {N,Z,C,V}.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_id` out 1: requester that owns the response.
- `rsp_result`, `rsp_resulthi` out 32 each: captured ALU results.
- `rsp_flags` out 4: captured flags.
- `rsp_divzero` out 1: DIV was issued with b == 0.
- `busy` out 1: the state is EXEC.

## Operation
- States are IDLE, EXEC and DONE.
- A request is acceptable in IDLE or DONE.
- Arbitration:
  - A single valid request wins.
  - If both are valid, the winner is the requester that is not `last_grant`.
  - `last_grant` updates on every accept.
- Accept cycle:
  - `req_ready[w]` = 1, asserted combinationally from state and `req_valid`.
  - The block latches `a`, `b`, `ctrl` and `w` into internal operand registers.
  - The latency counter is loaded with LAT−1, where LAT = 1 for 000–011, `LAT_MUL` for 101–111, and `LAT_DIV` for 100.
  - Next state is EXEC.
- EXEC:
  - `alu_a`, `alu_b` and `alu_ctrl` come from the operand registers and stay constant for the whole of EXEC.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, the block captures `alu_result`, `alu_resulthi`, `alu_flags` and `rsp_id` into the `rsp_*` registers.
  - Next state is DONE.
- DONE:
  - `rsp_valid` = 1 for exactly this cycle.
  - Next state is EXEC if a request is accepted, otherwise IDLE.
- DIV by zero:
  - When ctrl = 100 and latched b = 0, the block drives `alu_b` = 1 during EXEC so the ALU never sees a divide by zero.
  - The response is forced to `rsp_result` = 32'hFFFF_FFFF, `rsp_resulthi` = 0, `rsp_flags` = 4'b1000 and `rsp_divzero` = 1.
  - In every other case `rsp_divzero` = 0.
- `alu_*` outside EXEC: they drive the operand registers, which hold their last values. They are don't-care to consumers.
- Requests not granted stay pending. Requesters must hold `req_valid` and their operands until `req_ready`.

## Timing
Reset values, applied while `reset` = 0 at a clock edge:
- State is IDLE and the counter is 0.
- `last_grant` = 1, so requester 0 wins the first tie.
- `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_resulthi` = 0, `rsp_flags` = 0, `rsp_divzero` = 0.
- `busy` = 0, `req_ready` = 0.
- Operand registers and `alu_*` outputs = 0.

Latency and throughput:
- Latency from accept edge T to `rsp_valid` is LAT+1 cycles. `rsp_valid` is high in cycle T+LAT+1.
- Back-to-back single-cycle ops complete one every 2 cycles because accepts overlap DONE.

Reset mid-operation:
- Reset asserted during EXEC or DONE aborts the operation.
- No `rsp_valid` is produced for the aborted request.
- `req_ready` is 0 while `reset` = 0.

Simultaneous events:
- A new accept in DONE does not alter the `rsp_*` outputs of the current response.
- `rsp_*` outputs, other than `rsp_valid`, hold until the next capture.

## Test plan
- Single ADD: req0 a=5, b=7, ctrl=000 accepted in cycle 0. `rsp_valid` is high in cycle 2 with `rsp_id`=0, `rsp_result`=12, `rsp_flags`=0000.
- Tie and round-robin: both requesters held valid. Req0 SUB 3−3 is granted first and gives `rsp_result`=0, flags=0110. Req1 OR 0xF0|0x0F is granted second, with `req_ready`=10 in the DONE cycle, and gives 0xFF. Grants continue to alternate.
- SMUL with default latency: req1 a=−2, b=3, ctrl=110. `busy` is high for 2 cycles and `alu_*` are stable throughout. The response arrives 3 cycles after accept with `rsp_result`=0xFFFF_FFFA, `rsp_resulthi`=0xFFFF_FFFF, flags=1000.
- DIV by zero: a=10, b=0, ctrl=100. `alu_b` is 1 during EXEC. The response arrives 5 cycles after accept with `rsp_result`=0xFFFF_FFFF, `rsp_divzero`=1. A following DIV 100/7 gives 14 with `rsp_divzero`=0.
- Reset mid-op: UMUL accepted, then `reset`=0 in the first EXEC cycle. No `rsp_valid` appears, all outputs return to their reset values, and after reset a tie grants req0.
- Back-pressure: req1 is held valid while req0 issues three DIVs. Req1's operands change only after its `req_ready`, and its response matches the operands it held at accept.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands are held stable for a per-op latency so DIV/MUL can be multi-cycle paths.
//
// state | meaning
// IDLE  | no operation in flight, requests accepted
// EXEC  | ALU inputs held from operand registers, latency counter running
// DONE  | response valid this cycle, a new request may be accepted
module alu_arbiter #(
    parameter int unsigned LAT_MUL = 2,
    parameter int unsigned LAT_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_resulthi,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_resulthi,
    output logic [3:0]  rsp_flags,
    output logic        rsp_divzero,
    output logic        busy
);

    localparam logic [3:0] MUL_M1 = 4'(LAT_MUL - 1);
    localparam logic [3:0] DIV_M1 = 4'(LAT_DIV - 1);
    localparam logic [2:0] OP_DIV = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        id_q, id_d;
    logic        rid_q, rid_d;
    logic [31:0] rres_q, rres_d;
    logic [31:0] rhi_q, rhi_d;
    logic [3:0]  rflg_q, rflg_d;
    logic        rdz_q, rdz_d;

    logic        can_accept;
    logic        accept;
    logic        win;
    logic        op_divzero;

    function automatic logic [3:0] lat_m1(input logic [2:0] c);
        case (c)
            3'b100:                 return DIV_M1;
            3'b101, 3'b110, 3'b111: return MUL_M1;
            default:                return 4'd0;
        endcase
    endfunction

    assign op_divzero = (ctrl_q == OP_DIV) && (opb_q == 32'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        ctrl_d     = ctrl_q;
        id_d       = id_q;
        rid_d      = rid_q;
        rres_d     = rres_q;
        rhi_d      = rhi_q;
        rflg_d     = rflg_q;
        rdz_d      = rdz_q;
        req_ready  = 2'b00;

        can_accept = reset && (state_q != S_EXEC);
        win        = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        accept     = can_accept && (req_valid != 2'b00);

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    rid_d   = id_q;
                    // Divide by zero never reaches the response; ALU saw b=1 instead.
                    if (op_divzero) begin
                        rres_d = 32'hFFFF_FFFF;
                        rhi_d  = 32'd0;
                        rflg_d = 4'b1000;
                        rdz_d  = 1'b1;
                    end else begin
                        rres_d = alu_result;
                        rhi_d  = alu_resulthi;
                        rflg_d = alu_flags;
                        rdz_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = accept ? S_EXEC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            req_ready[win] = 1'b1;
            last_d         = win;
            id_d           = win;
            opa_d          = win ? req1_a    : req0_a;
            opb_d          = win ? req1_b    : req0_b;
            ctrl_d         = win ? req1_ctrl : req0_ctrl;
            cnt_d          = lat_m1(win ? req1_ctrl : req0_ctrl);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            ctrl_q  <= 3'd0;
            id_q    <= 1'b0;
            rid_q   <= 1'b0;
            rres_q  <= 32'd0;
            rhi_q   <= 32'd0;
            rflg_q  <= 4'd0;
            rdz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ctrl_q  <= ctrl_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            rres_q  <= rres_d;
            rhi_q   <= rhi_d;
            rflg_q  <= rflg_d;
            rdz_q   <= rdz_d;
        end
    end

    assign alu_a        = opa_q;
    assign alu_b        = ((state_q == S_EXEC) && op_divzero) ? 32'd1 : opb_q;
    assign alu_ctrl     = ctrl_q;
    assign busy         = (state_q == S_EXEC);
    // A response pending in DONE is dropped when reset is already low.
    assign rsp_valid    = (state_q == S_DONE) && reset;
    assign rsp_id       = rid_q;
    assign rsp_result   = rres_q;
    assign rsp_resulthi = rhi_q;
    assign rsp_flags    = rflg_q;
    assign rsp_divzero  = rdz_q;

endmodule
